// File: rtl/regfile_pkg.sv
// Shared constants, write-winner struct and the helper that picks the winning write port.
package regfile_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int MAX_WR     = 2;
  localparam int MAX_ADDR_W = 8;
  localparam int WR_IDX_W   = 1;
  localparam logic [MAX_ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic                hit;
    logic [WR_IDX_W-1:0] idx;
  } wr_win_t;

  // Ascending scan: the highest-index port hitting the address wins.
  function automatic wr_win_t wr_winner(input logic [MAX_WR-1:0]                 en,
                                        input logic [MAX_WR-1:0][MAX_ADDR_W-1:0] addr,
                                        input logic [MAX_ADDR_W-1:0]             a);
    wr_win_t w;
    w = '0;
    for (int j = 0; j < MAX_WR; j++)
      if (en[j] && addr[j] == a && a != ZERO_REG) begin
        w.hit = 1'b1;
        w.idx = WR_IDX_W'(j);
      end
    return w;
  endfunction
endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: zero-register squash, optional bypass (REGFILE_BYPASS_EN), output flops.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                rd_en_i,
  input  logic [ADDR_W-1:0]                   rd_addr_i,
  input  logic [DATA_W-1:0]                   rf_data_i,
  input  logic                                rf_pend_i,
  input  logic                                rf_pend_nxt_i,
  input  logic [MAX_WR-1:0]                   wr_en_i,
  input  logic [MAX_WR-1:0][MAX_ADDR_W-1:0]   wr_addr_i,
  input  logic [MAX_WR-1:0][DATA_W-1:0]       wr_data_i,
  output logic [DATA_W-1:0]                   rd_data_o,
  output logic                                rd_pend_o
);
  logic [DATA_W-1:0] data_d, data_q;
  logic              pend_d, pend_q;

`ifdef REGFILE_BYPASS_EN
  wr_win_t win;
  always_comb win = wr_winner(wr_en_i, wr_addr_i, MAX_ADDR_W'(rd_addr_i));
`else
  logic unused_bypass;
  assign unused_bypass = ^{rf_pend_nxt_i, wr_en_i, wr_addr_i, wr_data_i};
`endif

  always_comb begin
    data_d = rf_data_i;
    pend_d = rf_pend_i;
`ifdef REGFILE_BYPASS_EN
    // Forwarded data carries the post-write pending state (a same-cycle pend_set still wins).
    if (win.hit) begin
      data_d = wr_data_i[win.idx];
      pend_d = rf_pend_nxt_i;
    end
`endif
    if (rd_addr_i == ZERO_REG[ADDR_W-1:0]) begin
      data_d = '0;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      data_q <= '0;
      pend_q <= 1'b0;
    end else if (rd_en_i) begin
      data_q <= data_d;
      pend_q <= pend_d;
    end

  assign rd_data_o = data_q;
  assign rd_pend_o = pend_q;
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with r0 hard-wired to zero and a pending scoreboard.
// Optional same-cycle write-to-read bypass selected by REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_pend,
  input  logic [NUM_WR-1:0]          wr_en,
  input  logic [NUM_WR*ADDR_W-1:0]   wr_addr,
  input  logic [NUM_WR*DATA_W-1:0]   wr_data,
  input  logic                       pend_set,
  input  logic [ADDR_W-1:0]          pend_addr,
  output logic                       wr_conflict
);
  localparam int DEPTH = 2**ADDR_W;

  // Write ports padded to MAX_WR so the package helper sees a fixed shape.
  logic [MAX_WR-1:0]                 wen_p;
  logic [MAX_WR-1:0][MAX_ADDR_W-1:0] waddr_p;
  logic [MAX_WR-1:0][DATA_W-1:0]     wdata_p;

  always_comb begin
    wen_p   = '0;
    waddr_p = '0;
    wdata_p = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wen_p[j]   = wr_en[j];
      waddr_p[j] = MAX_ADDR_W'(wr_addr[j*ADDR_W +: ADDR_W]);
      wdata_p[j] = wr_data[j*DATA_W +: DATA_W];
    end
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  wr_win_t           win   [DEPTH];
  logic              conflict_d, wr_conflict_q;

  always_comb
    for (int k = 0; k < DEPTH; k++)
      win[k] = wr_winner(wen_p, waddr_p, MAX_ADDR_W'(k));

  // Accepted writes clear; a same-cycle issue to the same destination re-arms it.
  always_comb begin
    pend_d = pend_q;
    for (int j = 0; j < MAX_WR; j++)
      if (wen_p[j] && waddr_p[j] != ZERO_REG)
        pend_d[waddr_p[j][ADDR_W-1:0]] = 1'b0;
    if (pend_set && pend_addr != ZERO_REG[ADDR_W-1:0])
      pend_d[pend_addr] = 1'b1;
  end

  always_comb begin
    conflict_d = 1'b0;
    for (int i = 0; i < MAX_WR; i++)
      for (int j = i + 1; j < MAX_WR; j++)
        if (wen_p[i] && wen_p[j] && waddr_p[i] == waddr_p[j] && waddr_p[i] != ZERO_REG)
          conflict_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
      pend_q        <= '0;
      wr_conflict_q <= 1'b0;
    end else begin
      for (int k = 1; k < DEPTH; k++)
        if (win[k].hit) mem_q[k] <= wdata_p[win[k].idx];
      pend_q        <= pend_d;
      wr_conflict_q <= conflict_d;
    end

  assign wr_conflict = wr_conflict_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    assign ra = rd_addr[i*ADDR_W +: ADDR_W];

    regfile_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .rd_en_i       (rd_en[i]),
      .rd_addr_i     (ra),
      .rf_data_i     (mem_q[ra]),
      .rf_pend_i     (pend_q[ra]),
      .rf_pend_nxt_i (pend_d[ra]),
      .wr_en_i       (wen_p),
      .wr_addr_i     (waddr_p),
      .wr_data_i     (wdata_p),
      .rd_data_o     (rd_data[i*DATA_W +: DATA_W]),
      .rd_pend_o     (rd_pend[i])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Randomized bench for regfile_mp (2 read, 2 write ports) against an array-based reference model.
// Expectations follow REGFILE_BYPASS_EN the same way the design build does.
module tb_regfile_mp;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_pend;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        pend_set;
  logic [4:0]  pend_addr;
  logic        wr_conflict;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_reg  [32];
  logic        m_pend [32];
  logic [31:0] exp_rd [2];
  logic        exp_pd [2];
  logic        exp_cf;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_pend(rd_pend), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .pend_set(pend_set), .pend_addr(pend_addr), .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".rd0"}, rd_data[31:0],  exp_rd[0]);
    chk({tag, ".rd1"}, rd_data[63:32], exp_rd[1]);
    chk({tag, ".pd0"}, 32'(rd_pend[0]), 32'(exp_pd[0]));
    chk({tag, ".pd1"}, 32'(rd_pend[1]), 32'(exp_pd[1]));
    chk({tag, ".cf"},  32'(wr_conflict), 32'(exp_cf));
  endtask

  task automatic model_reset();
    for (int a = 0; a < 32; a++) begin
      m_reg[a]  = '0;
      m_pend[a] = 1'b0;
    end
    exp_rd[0] = '0; exp_rd[1] = '0;
    exp_pd[0] = 1'b0; exp_pd[1] = 1'b0;
    exp_cf    = 1'b0;
  endtask

  // One clock: drive, advance the model across the edge, compare 1 time unit later.
  task automatic step(input string tag, input logic [1:0] ren, input logic [4:0] ra0, input logic [4:0] ra1,
                      input logic [1:0] wen, input logic [4:0] wa0, input logic [31:0] wd0,
                      input logic [4:0] wa1, input logic [31:0] wd1, input logic ps, input logic [4:0] pa);
    logic [31:0] nreg  [32];
    logic        npend [32];
    logic [4:0]  ra [2];
    logic [4:0]  wa [2];
    logic [31:0] wd [2];
    logic        written;
    ra[0] = ra0; ra[1] = ra1; wa[0] = wa0; wa[1] = wa1; wd[0] = wd0; wd[1] = wd1;
    rd_en = ren; rd_addr = {ra1, ra0};
    wr_en = wen; wr_addr = {wa1, wa0}; wr_data = {wd1, wd0};
    pend_set = ps; pend_addr = pa;
    @(posedge clk);
    nreg = m_reg; npend = m_pend;
    for (int j = 0; j < 2; j++)
      if (wen[j] && wa[j] != 0) begin
        nreg[wa[j]]  = wd[j];
        npend[wa[j]] = 1'b0;
      end
    if (ps && pa != 0) npend[pa] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      written = (wen[0] && wa[0] == ra[i]) || (wen[1] && wa[1] == ra[i]);
      if (ren[i]) begin
        if (ra[i] == 0) begin
          exp_rd[i] = '0; exp_pd[i] = 1'b0;
        end else if (BYP && written) begin
          exp_rd[i] = nreg[ra[i]]; exp_pd[i] = npend[ra[i]];
        end else begin
          exp_rd[i] = m_reg[ra[i]]; exp_pd[i] = m_pend[ra[i]];
        end
      end
    end
    exp_cf = (wen == 2'b11) && (wa0 == wa1) && (wa0 != 0);
    m_reg = nreg; m_pend = npend;
    #1;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_outputs(tag);
    rst_n = 1'b1;
    #2;
  endtask

  initial begin
    logic [1:0]  ren, wen;
    logic [4:0]  ra0, ra1, wa0, wa1, pa;
    logic [31:0] wd0, wd1;
    logic        ps;

    rst_n = 1'b0; rd_en = '0; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
    pend_set = 1'b0; pend_addr = '0;
    model_reset();
    #3;
    check_outputs("por");
    #4 rst_n = 1'b1;

    // Reset clears contents mid-run.
    step("w_r5", 2'b00, 5'd0, 5'd0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 1'b0, 5'd0);
    step("rd_r5_pre", 2'b01, 5'd5, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("r5_written", rd_data[31:0], 32'hDEADBEEF);
    reset_pulse("mid_rst");
    step("rd_r5_post", 2'b11, 5'd5, 5'd5, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("r5_cleared", rd_data[31:0], 32'h0);

    // Zero register.
    step("w_r0", 2'b00, 5'd0, 5'd0, 2'b11, 5'd0, 32'h12345678, 5'd0, 32'h12345678, 1'b1, 5'd0);
    step("rd_r0", 2'b11, 5'd0, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("r0_zero", rd_data[63:32], 32'h0);

    // Back-to-back write then read.
    step("w_r7", 2'b00, 5'd0, 5'd0, 2'b01, 5'd7, 32'hA5A5A5A5, 5'd0, 32'd0, 1'b0, 5'd0);
    step("rd_r7", 2'b10, 5'd0, 5'd7, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("r7_b2b", rd_data[63:32], 32'hA5A5A5A5);

    // Same-cycle read/write.
    step("w_r9", 2'b00, 5'd0, 5'd0, 2'b01, 5'd9, 32'h1, 5'd0, 32'd0, 1'b0, 5'd0);
    step("rw_r9", 2'b01, 5'd9, 5'd0, 2'b10, 5'd0, 32'd0, 5'd9, 32'h2, 1'b0, 5'd0);
    chk("r9_same", rd_data[31:0], BYP ? 32'h2 : 32'h1);

    // Write collision.
    step("coll", 2'b00, 5'd0, 5'd0, 2'b11, 5'd3, 32'h11, 5'd3, 32'h22, 1'b0, 5'd0);
    chk("coll_flag", 32'(wr_conflict), 32'h1);
    step("rd_r3", 2'b01, 5'd3, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("r3_win", rd_data[31:0], 32'h22);
    chk("coll_drop", 32'(wr_conflict), 32'h0);

    // Scoreboard.
    step("ps_r4", 2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd4);
    step("rd_r4a", 2'b01, 5'd4, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("r4_pend_set", 32'(rd_pend[0]), 32'h1);
    step("w_ps_r4", 2'b00, 5'd0, 5'd0, 2'b01, 5'd4, 32'h44, 5'd0, 32'd0, 1'b1, 5'd4);
    step("rd_r4b", 2'b10, 5'd0, 5'd4, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("r4_set_wins", 32'(rd_pend[1]), 32'h1);
    step("w_r4", 2'b00, 5'd0, 5'd0, 2'b10, 5'd0, 32'd0, 5'd4, 32'h45, 1'b0, 5'd0);
    step("rd_r4c", 2'b01, 5'd4, 5'd0, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0);
    chk("r4_cleared", 32'(rd_pend[0]), 32'h0);

    // Random traffic on a narrow address window to provoke hazards and collisions.
    for (int n = 0; n < 400; n++) begin
      ren = 2'($urandom_range(0, 3));
      wen = 2'($urandom_range(0, 3));
      ra0 = 5'($urandom_range(0, 7)); ra1 = 5'($urandom_range(0, 7));
      wa0 = 5'($urandom_range(0, 7)); wa1 = 5'($urandom_range(0, 7));
      wd0 = $urandom; wd1 = $urandom;
      ps  = ($urandom_range(0, 2) == 0);
      pa  = 5'($urandom_range(0, 7));
      step("rnd", ren, ra0, ra1, wen, wa0, wd0, wa1, wd1, ps, pa);
      if (n == 200) reset_pulse("rnd_rst");
    end
    idle("tail");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
